// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the cache fill path (fill_mem_responder and
// cache_fill_FSM).
//   WORD_W       : width of one backing-store word in bits
//   ADDR_W       : width of a byte address in bits
//   MEM_LATENCY  : default request-to-response latency of the fill memory
//   req_kind_e   : decoded meaning of a request in a given cycle
//   classify_req : decodes valid/wr/address-lsb into a req_kind_e
// -----------------------------------------------------------------------------
package cache_pkg;

    localparam int WORD_W      = 16;
    localparam int ADDR_W      = 16;
    localparam int MEM_LATENCY = 4;

    typedef enum logic [1:0] {
        REQ_IDLE  = 2'd0,
        REQ_READ  = 2'd1,
        REQ_WRITE = 2'd2,
        REQ_DROP  = 2'd3
    } req_kind_e;

    // An odd byte address cannot name a 16-bit word, so such a request is
    // dropped regardless of direction.
    function automatic req_kind_e classify_req(input logic valid,
                                               input logic wr,
                                               input logic addr_lsb);
        req_kind_e kind;
        if (!valid) begin
            kind = REQ_IDLE;
        end else if (addr_lsb) begin
            kind = REQ_DROP;
        end else if (wr) begin
            kind = REQ_WRITE;
        end else begin
            kind = REQ_READ;
        end
        return kind;
    endfunction

endpackage

// File: rtl/mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// Backing store for fill_mem_responder: one synchronous write port and one
// asynchronous (combinational) read port. Contents are never reset.
//   clk   : write clock, rising edge
//   we    : write enable
//   waddr : word index written
//   wdata : word written
//   raddr : word index read
//   rdata : current contents at raddr (value before any write at this edge)
// -----------------------------------------------------------------------------
module mem_array
    import cache_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12,
    parameter int DATA_W     = WORD_W
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_W-1:0]     rdata
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fill_mem_responder.sv
// -----------------------------------------------------------------------------
// fill_mem_responder
// Fixed-latency memory model answering cache fill requests. Every request is
// accepted on the edge it is presented (no backpressure). Writes update the
// store at that edge; reads snapshot the store at that edge and the result
// travels through a LATENCY-deep shift pipeline before being registered onto
// the response port, so rsp_valid rises in the cycle after edge E0+LATENCY.
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset (store is not cleared)
//   req_valid      : request present this cycle
//   req_wr         : 1 = write, 0 = read
//   req_addr       : byte address, must be 2-byte aligned
//   req_wdata      : write data
//   rsp_valid      : one-cycle pulse per completed read
//   rsp_data       : read data, 0 when rsp_valid is low
//   rsp_addr       : read address echo, 0 when rsp_valid is low
//   err_misaligned : pulse in the cycle after an odd-address request
//   outstanding    : reads accepted and not yet responded
// -----------------------------------------------------------------------------
module fill_mem_responder
    import cache_pkg::*;
#(
    parameter int LATENCY    = MEM_LATENCY,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              err_misaligned,
    output logic [3:0]        outstanding
);

    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $error("fill_mem_responder: LATENCY must be within 1..8");
    end

    if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > ADDR_W - 1) begin : g_bad_depth
        $error("fill_mem_responder: DEPTH_LOG2 must be within 1..ADDR_W-1");
    end

    // Request decode
    req_kind_e             req_kind;
    logic                  rd_accept;
    logic                  wr_accept;
    logic                  rsp_issue;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [WORD_W-1:0]     mem_rdata;

    // Read pipeline: stage k holds a read accepted k edges ago
    logic                  vld_p  [LATENCY];
    logic [ADDR_W-1:0]     addr_p [LATENCY];
    logic [WORD_W-1:0]     data_p [LATENCY];

    assign req_kind  = classify_req(req_valid, req_wr, req_addr[0]);
    assign rd_accept = (req_kind == REQ_READ);
    // Keep the store untouched while reset is held, even if a requester
    // keeps driving a write.
    assign wr_accept = (req_kind == REQ_WRITE) && rst_n;
    assign rsp_issue = vld_p[LATENCY-1];

    // Upper address bits above the store depth are ignored, wrapping the
    // address space onto the store.
    assign word_idx  = req_addr[DEPTH_LOG2:1];

    mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (WORD_W)
    ) u_mem_array (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (word_idx),
        .wdata (req_wdata),
        .raddr (word_idx),
        .rdata (mem_rdata)
    );

    // ---- stage 0 .. LATENCY-1: control (valid) shift and counters ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LATENCY; k++) begin
                vld_p[k] <= 1'b0;
            end
            rsp_valid      <= 1'b0;
            err_misaligned <= 1'b0;
            outstanding    <= 4'd0;
        end else begin
            vld_p[0] <= rd_accept;
            for (int k = 1; k < LATENCY; k++) begin
                vld_p[k] <= vld_p[k-1];
            end
            rsp_valid      <= rsp_issue;
            err_misaligned <= (req_kind == REQ_DROP);
            // Accept and issue in the same edge cancel out.
            outstanding    <= outstanding + {3'b000, rd_accept} - {3'b000, rsp_issue};
        end
    end

    // ---- stage 0 .. LATENCY-1: data shift (qualified by vld_p, unreset) ----
    always_ff @(posedge clk) begin
        addr_p[0] <= req_addr;
        data_p[0] <= mem_rdata;
        for (int k = 1; k < LATENCY; k++) begin
            addr_p[k] <= addr_p[k-1];
            data_p[k] <= data_p[k-1];
        end
    end

    // ---- output stage: response registers, zeroed when no response ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_addr <= '0;
        end else if (rsp_issue) begin
            rsp_data <= data_p[LATENCY-1];
            rsp_addr <= addr_p[LATENCY-1];
        end else begin
            rsp_data <= '0;
            rsp_addr <= '0;
        end
    end

endmodule

// File: tb/tb_fill_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_fill_mem_responder
// Self-checking bench for fill_mem_responder. A reference model keeps the
// store as a plain array and pending reads as a queue of {due edge, addr,
// data}; every request step compares all DUT outputs against it.
// -----------------------------------------------------------------------------
module tb_fill_mem_responder;

    localparam int LAT = 4;
    localparam int DL2 = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic [15:0] rsp_addr;
    logic        err_misaligned;
    logic [3:0]  outstanding;

    always #5 clk = ~clk;

    fill_mem_responder #(
        .LATENCY    (LAT),
        .DEPTH_LOG2 (DL2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_addr       (rsp_addr),
        .err_misaligned (err_misaligned),
        .outstanding    (outstanding)
    );

    typedef struct {
        int          due;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          peak   = 0;
    logic [15:0] mem_m [0:(1<<DL2)-1];
    exp_t        exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [15:0] a);
        return int'(a[DL2:1]);
    endfunction

    // One clock edge with the given request presented, then a full compare.
    task automatic step(input logic v, input logic wr, input logic [15:0] a, input logic [15:0] d);
        exp_t        e;
        logic        ev;
        logic [15:0] ea;
        logic [15:0] ed;
        @(negedge clk);
        req_valid = v;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        cyc++;
        if (v && !a[0]) begin
            if (!wr) begin
                e.due  = cyc + LAT;
                e.addr = a;
                e.data = mem_m[widx(a)];
                exp_q.push_back(e);
            end else begin
                mem_m[widx(a)] = d;
            end
        end
        ev = 1'b0;
        ea = '0;
        ed = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            ev = 1'b1;
            ea = exp_q[0].addr;
            ed = exp_q[0].data;
            void'(exp_q.pop_front());
        end
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        chk("rsp_data", 32'(rsp_data), 32'(ed));
        chk("rsp_addr", 32'(rsp_addr), 32'(ea));
        chk("err_misaligned", 32'(err_misaligned), 32'(v & a[0]));
        chk("outstanding", 32'(outstanding), 32'(exp_q.size()));
        if (int'(outstanding) > peak) peak = int'(outstanding);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        chk({tag, "_rsp_addr"}, 32'(rsp_addr), 32'd0);
        chk({tag, "_err"}, 32'(err_misaligned), 32'd0);
        chk({tag, "_outstanding"}, 32'(outstanding), 32'd0);
    endtask

    // Called 1 time unit after an edge: pulls reset low for 10 ns, spanning
    // one clock edge, and releases it before the following negedge.
    task automatic mid_reset();
        req_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("in_reset");
        exp_q.delete();
        #9;
        chk_outputs_zero("in_reset_late");
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          hit;
        logic [15:0] a;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        #3;
        chk_outputs_zero("reset");
        #9;
        rst_n = 1'b1;

        // Give the low words known contents.
        for (int i = 0; i < 64; i++) step(1'b1, 1'b1, 16'(i * 2), 16'($urandom));

        // Write then read the same word on the next edge.
        step(1'b1, 1'b1, 16'h1000, 16'hBEEF);
        step(1'b1, 1'b0, 16'h1000, 16'h0000);
        hit = -1;
        for (int k = 1; k <= LAT + 1; k++) begin
            step(1'b0, 1'b0, 16'h0000, 16'h0000);
            if (rsp_valid && hit < 0) begin
                hit = k;
                chk("beef_data", 32'(rsp_data), 32'h0000BEEF);
                chk("beef_addr", 32'(rsp_addr), 32'h00001000);
            end
        end
        chk("beef_latency", 32'(hit), 32'(LAT));

        // Back-to-back reads stream out in order.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 16'(16'h1230 + 2 * i), 16'(16'hA000 + i));
        peak = 0;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'(16'h1230 + 2 * i), 16'h0000);
        idle(LAT + 1);
        chk("burst_peak_outstanding", 32'(peak), 32'(LAT));

        // Read-before-write ordering around the same word.
        step(1'b1, 1'b0, 16'h0040, 16'h0000);
        step(1'b1, 1'b1, 16'h0040, 16'h5555);
        step(1'b1, 1'b0, 16'h0040, 16'h0000);
        idle(LAT + 1);

        // Misaligned write is dropped.
        step(1'b1, 1'b1, 16'h0003, 16'h1111);
        step(1'b1, 1'b0, 16'h0002, 16'h0000);
        idle(LAT + 1);

        // Reset with reads in flight: none may ever answer.
        step(1'b1, 1'b0, 16'h0004, 16'h0000);
        step(1'b1, 1'b0, 16'h0006, 16'h0000);
        step(1'b1, 1'b0, 16'h0008, 16'h0000);
        mid_reset();
        // First edge after release must accept.
        step(1'b1, 1'b1, 16'h0010, 16'h1234);
        step(1'b1, 1'b0, 16'h0010, 16'h0000);
        idle(LAT + 2);
        chk("post_reset_outstanding", 32'(outstanding), 32'd0);

        // Upper address bits wrap onto the store.
        step(1'b1, 1'b1, 16'h2002, 16'h7777);
        step(1'b1, 1'b0, 16'h0002, 16'h0000);
        idle(LAT + 1);

        // Random traffic over a small set of words to provoke hazards.
        for (int n = 0; n < 600; n++) begin
            a[15:13] = 3'($urandom_range(0, 7));
            a[12:5]  = 8'h00;
            a[4:1]   = 4'($urandom_range(0, 15));
            a[0]     = ($urandom_range(0, 7) == 0);
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, 16'($urandom));
        end
        idle(LAT + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fill_mem_responder.md
FILL_MEM_RESPONDER -- requirements
Module: fill_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning cycles from request acceptance to response, legal range 1..8.
REQ-002 SHALL have parameter DEPTH_LOG2, default 12, meaning log2 of backing store depth in 16-bit words.
REQ-003 SHALL have port clk  input  1  clock, rising-edge active.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  request present this cycle.
REQ-006 SHALL have port req_wr  input  1  1 = write, 0 = read; qualified by req_valid.
REQ-007 SHALL have port req_addr  input  16  byte address, 2-byte aligned.
REQ-008 SHALL have port req_wdata  input  16  write data.
REQ-009 SHALL have port rsp_valid  output  1  read response valid, one-cycle pulse per read.
REQ-010 SHALL have port rsp_data  output  16  read data, meaningful only with rsp_valid.
REQ-011 SHALL have port rsp_addr  output  16  echo of the read's req_addr, aligned with rsp_data.
REQ-012 SHALL have port err_misaligned  output  1  one-cycle pulse: a request with req_addr[0]=1 was dropped.
REQ-013 SHALL have port outstanding  output  4  count of accepted reads not yet responded.

Function
REQ-014 SHALL accept one request at every rising edge where req_valid=1; no backpressure, no stall.
REQ-015 SHALL index the store with word index req_addr[DEPTH_LOG2:1]; upper address bits ignored (wrap modulo depth).
REQ-016 SHALL perform a write at its acceptance edge; writes produce no response.
REQ-017 SHALL sample read data at the read's acceptance edge E0 and assert rsp_valid for exactly the cycle following edge E0+LATENCY.
REQ-018 SHALL keep reads fully pipelined: reads on consecutive edges give rsp_valid on consecutive cycles, in order.
REQ-019 SHALL return, for a read at E0, contents as of before E0's write; a write accepted at E0-1 or earlier is visible, a write accepted after E0 is not.
REQ-020 SHALL drop a misaligned request (no write, no response) and pulse err_misaligned in the cycle after its acceptance edge.
REQ-021 SHALL drive rsp_data and rsp_addr to 0 in cycles where rsp_valid=0.
REQ-022 SHALL update outstanding each edge as +1 per accepted aligned read, -1 per response issued; simultaneous accept and issue leave it unchanged; maximum value LATENCY.
REQ-023 SHALL implement delay as a LATENCY-deep shift pipeline of {valid, addr, data}; no per-request counters.

Reset
REQ-024 SHALL on rst_n=0 immediately clear rsp_valid, rsp_data, rsp_addr, err_misaligned, outstanding and all pipeline valid bits to 0.
REQ-025 SHALL discard in-flight reads on reset mid-operation; no response for them ever appears after reset release.
REQ-026 SHALL NOT clear backing store contents on reset.
REQ-027 SHALL accept requests at the first rising edge after rst_n deasserts.

Structure
REQ-028 SHALL take WORD_W=16, ADDR_W=16 and MEM_LATENCY=4 from shared package cache_pkg, also used by cache_fill_FSM.
REQ-029 SHALL instantiate one sub-module mem_array: 1 write port synchronous, 1 read port asynchronous, depth 2**DEPTH_LOG2.
REQ-030 SHALL keep all pipeline, counter and error logic in fill_mem_responder, none in mem_array.

Verification
REQ-031 SHALL cover: write 0x1000<-0xBEEF at E0, read 0x1000 at E1 -> rsp_valid after E5, rsp_data=0xBEEF, rsp_addr=0x1000.
REQ-032 SHALL cover: 8 back-to-back reads 0x1230..0x123E after preloading word i with 0xA000+i -> 8 consecutive rsp_valid cycles, data 0xA000..0xA007 in order; outstanding peaks at 4.
REQ-033 SHALL cover: read 0x0040 at E0, write 0x0040<-0x5555 at E1 -> response returns old value; a second read at E2 returns 0x5555.
REQ-034 SHALL cover: request addr 0x0003 write 0x1111 -> err_misaligned pulse after E0, word 0x0002 unchanged, no rsp_valid.
REQ-035 SHALL cover: 3 reads accepted, rst_n low 10 ns at E2 -> outputs 0 during reset, no rsp_valid for any of them afterward, outstanding=0.
REQ-036 SHALL cover: DEPTH_LOG2=12, write 0x2002<-0x7777, read 0x0002 -> 0x7777 (wrap).
